// File: rtl/ecc_isa_pkg.sv
// ECC ISA definitions shared by the ALU, decode and writeback stages.
package ecc_isa_pkg;

   // 5-bit opcode map
   typedef enum logic [4:0] {
      OP_NOP   = 5'b00000,
      OP_BRZ   = 5'b00001,
      OP_BRZP  = 5'b00010,
      OP_BRNP  = 5'b00011,
      OP_BRNZ  = 5'b00100,
      OP_ADD   = 5'b00101,
      OP_SUB   = 5'b00110,
      OP_ADDI  = 5'b00111,
      OP_JSR   = 5'b01000,
      OP_AND   = 5'b01001,
      OP_RTI   = 5'b01010,
      OP_CONST = 5'b01011,
      OP_SLL   = 5'b01100,
      OP_SRL   = 5'b01101,
      OP_SDRH  = 5'b01110,
      OP_SDRL  = 5'b01111,
      OP_CHKL  = 5'b10000,
      OP_SDL   = 5'b10010,
      OP_CHKH  = 5'b10011,
      OP_TCS   = 5'b10100,
      OP_TCDH  = 5'b10101
   } opcode_e;

   // Instruction field positions
   localparam int OPC_MSB = 19;
   localparam int OPC_LSB = 15;
   localparam int RD_MSB  = 14;
   localparam int RD_LSB  = 10;

   // JSR link register and flag reset value ({N,Z,P})
   localparam logic [4:0] LINK_REG  = 5'd7;
   localparam logic [2:0] NZP_RESET = 3'b010;

   // Opcodes that load rd with the ALU result and update NZP
   function automatic logic is_write_op(input opcode_e op);
      case (op)
         OP_ADD, OP_SUB, OP_ADDI, OP_AND, OP_CONST, OP_SLL, OP_SRL,
         OP_SDRH, OP_SDRL, OP_SDL, OP_TCS, OP_TCDH: is_write_op = 1'b1;
         default:                                  is_write_op = 1'b0;
      endcase
   endfunction

   // Branch condition against the flags {N,Z,P}
   function automatic logic branch_taken(input opcode_e op, input logic [2:0] nzp);
      case (op)
         OP_BRZ:  branch_taken = nzp[1];
         OP_BRZP: branch_taken = nzp[1] | nzp[0];
         OP_BRNP: branch_taken = nzp[2] | nzp[0];
         OP_BRNZ: branch_taken = nzp[2] | nzp[1];
         default: branch_taken = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ecc_nzp_detect.sv
// Combinational sign / zero classification of a wide result into {N,Z,P}.
module ecc_nzp_detect #(
   parameter int WORD_SIZE = 256
) (
   input  logic [WORD_SIZE-1:0] data_i,
   output logic [2:0]           nzp_o
);

   logic neg;
   logic zero;

   // Sign bit and wide zero reduction
   always_comb begin
      neg   = data_i[WORD_SIZE-1];
      zero  = ~(|data_i);
      nzp_o = {neg, zero, ~neg & ~zero};
   end

endmodule

// File: rtl/ecc_writeback_stage.sv
// Execute-to-writeback stage: flags, carry, branch/JSR/RTI redirect and a
// one-entry register-file write buffer with valid/ready backpressure.
module ecc_writeback_stage #(
   parameter int WORD_SIZE = 256,
   parameter int INSN      = 19,
   parameter int IADDR     = 10,
   parameter int DADDR     = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [INSN:0]        i_insn,
   input  logic [IADDR:0]       i_pc,
   input  logic [WORD_SIZE-1:0] i_result,
   output logic                 o_carry,
   output logic [2:0]           o_nzp,
   output logic                 o_redirect,
   output logic [IADDR:0]       o_redirect_pc,
   output logic                 o_wb_valid,
   input  logic                 i_wb_ready,
   output logic [DADDR:0]       o_wb_rd,
   output logic [WORD_SIZE-1:0] o_wb_data
);
   import ecc_isa_pkg::*;

   localparam logic [IADDR+1:0] PC_ONE = {{(IADDR+1){1'b0}}, 1'b1};

   logic                 wb_valid_q, wb_valid_d;
   logic [DADDR:0]       wb_rd_q, wb_rd_d;
   logic [WORD_SIZE-1:0] wb_data_q, wb_data_d;
   logic [2:0]           nzp_q, nzp_d;
   logic                 carry_q, carry_d;
   logic                 redirect_q, redirect_d;
   logic [IADDR:0]       redirect_pc_q, redirect_pc_d;

   opcode_e              opc;
   logic [2:0]           res_nzp;
   logic                 accept;
   logic                 live;
   logic                 unused_insn;

   assign opc         = opcode_e'(i_insn[OPC_MSB:OPC_LSB]);
   assign unused_insn = ^i_insn[RD_LSB-1:0];

   ecc_nzp_detect #(.WORD_SIZE(WORD_SIZE)) u_nzp (
      .data_i (i_result),
      .nzp_o  (res_nzp)
   );

   // Handshake: accept whenever the write buffer is empty or draining;
   // anything accepted during a redirect pulse is a wrong-path instruction.
   always_comb begin
      o_ready = ~wb_valid_q | i_wb_ready;
      accept  = i_valid & o_ready;
      live    = accept & ~redirect_q;
   end

   // Next-state decode for flags, carry, redirect and the write buffer
   always_comb begin
      wb_valid_d    = wb_valid_q & ~i_wb_ready;
      wb_rd_d       = wb_rd_q;
      wb_data_d     = wb_data_q;
      nzp_d         = nzp_q;
      carry_d       = carry_q;
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      if (live) begin
         case (opc)
            OP_JSR: begin
               wb_valid_d    = 1'b1;
               wb_rd_d       = (DADDR+1)'(LINK_REG);
               wb_data_d     = WORD_SIZE'({1'b0, i_pc} + PC_ONE);
               redirect_d    = 1'b1;
               redirect_pc_d = i_result[IADDR:0];
            end
            OP_RTI: begin
               redirect_d    = 1'b1;
               redirect_pc_d = i_result[IADDR:0];
            end
            OP_BRZ, OP_BRZP, OP_BRNP, OP_BRNZ: begin
               if (branch_taken(opc, nzp_q)) begin
                  redirect_d    = 1'b1;
                  redirect_pc_d = i_result[IADDR:0];
               end
            end
            OP_CHKL: carry_d = i_result[0];
            OP_CHKH: carry_d = i_result[WORD_SIZE-1];
            default: begin
               if (is_write_op(opc)) begin
                  wb_valid_d = 1'b1;
                  wb_rd_d    = (DADDR+1)'(i_insn[RD_MSB:RD_LSB]);
                  wb_data_d  = i_result;
                  nzp_d      = res_nzp;
               end
            end
         endcase
      end
   end

   // State registers; reset drops any pending write immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid_q    <= 1'b0;
         wb_rd_q       <= '0;
         wb_data_q     <= '0;
         nzp_q         <= NZP_RESET;
         carry_q       <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         wb_valid_q    <= wb_valid_d;
         wb_rd_q       <= wb_rd_d;
         wb_data_q     <= wb_data_d;
         nzp_q         <= nzp_d;
         carry_q       <= carry_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   assign o_wb_valid    = wb_valid_q;
   assign o_wb_rd       = wb_rd_q;
   assign o_wb_data     = wb_data_q;
   assign o_nzp         = nzp_q;
   assign o_carry       = carry_q;
   assign o_redirect    = redirect_q;
   assign o_redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_ecc_writeback_stage.sv
// Testbench for ecc_writeback_stage: directed scenarios plus a randomized
// run against a behavioural reference model.
module tb_ecc_writeback_stage;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_valid = 1'b0;
   logic         o_ready;
   logic [19:0]  i_insn = '0;
   logic [10:0]  i_pc = '0;
   logic [255:0] i_result = '0;
   logic         o_carry;
   logic [2:0]   o_nzp;
   logic         o_redirect;
   logic [10:0]  o_redirect_pc;
   logic         o_wb_valid;
   logic         i_wb_ready = 1'b1;
   logic [4:0]   o_wb_rd;
   logic [255:0] o_wb_data;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ecc_writeback_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_valid       (i_valid),
      .o_ready       (o_ready),
      .i_insn        (i_insn),
      .i_pc          (i_pc),
      .i_result      (i_result),
      .o_carry       (o_carry),
      .o_nzp         (o_nzp),
      .o_redirect    (o_redirect),
      .o_redirect_pc (o_redirect_pc),
      .o_wb_valid    (o_wb_valid),
      .i_wb_ready    (i_wb_ready),
      .o_wb_rd       (o_wb_rd),
      .o_wb_data     (o_wb_data)
   );

   // Reference model state
   logic         m_wbv, m_carry, m_redir;
   logic [4:0]   m_rd;
   logic [255:0] m_data;
   logic [2:0]   m_nzp;
   logic [10:0]  m_rpc;

   task automatic model_reset();
      m_wbv = 0; m_rd = 0; m_data = 0; m_nzp = 3'b010;
      m_carry = 0; m_redir = 0; m_rpc = 0;
   endtask

   // Advance one clock: model computes from the instruction-level rules,
   // then commits together with the DUT edge.
   task automatic tick();
      logic acc, tk;
      logic [4:0] op;
      logic         n_wbv, n_carry, n_redir;
      logic [4:0]   n_rd;
      logic [255:0] n_data;
      logic [2:0]   n_nzp;
      logic [10:0]  n_rpc;
      acc = i_valid && (!m_wbv || i_wb_ready);
      n_wbv = m_wbv && !i_wb_ready; n_rd = m_rd; n_data = m_data;
      n_nzp = m_nzp; n_carry = m_carry; n_redir = 0; n_rpc = m_rpc;
      op = i_insn[19:15];
      if (acc && !m_redir) begin
         if (op inside {5'd5, 5'd6, 5'd7, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd18, 5'd20, 5'd21}) begin
            n_wbv = 1; n_rd = i_insn[14:10]; n_data = i_result;
            if (i_result == 256'd0) n_nzp = 3'b010;
            else if (i_result[255]) n_nzp = 3'b100;
            else n_nzp = 3'b001;
         end else if (op == 5'd8) begin
            n_wbv = 1; n_rd = 5'd7; n_data = 256'(i_pc) + 256'd1;
            n_redir = 1; n_rpc = i_result[10:0];
         end else if (op == 5'd10) begin
            n_redir = 1; n_rpc = i_result[10:0];
         end else if (op inside {5'd1, 5'd2, 5'd3, 5'd4}) begin
            case (op)
               5'd1:    tk = m_nzp == 3'b010;
               5'd2:    tk = m_nzp != 3'b100;
               5'd3:    tk = m_nzp != 3'b010;
               default: tk = m_nzp != 3'b001;
            endcase
            if (tk) begin n_redir = 1; n_rpc = i_result[10:0]; end
         end else if (op == 5'd16) n_carry = i_result[0];
         else if (op == 5'd19) n_carry = i_result[255];
      end
      @(posedge clk);
      #1;
      m_wbv = n_wbv; m_rd = n_rd; m_data = n_data; m_nzp = n_nzp;
      m_carry = n_carry; m_redir = n_redir; m_rpc = n_rpc;
   endtask

   task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] rd,
                        input logic [10:0] pc, input logic [255:0] res);
      i_valid = v; i_insn = {op, rd, 10'($urandom)}; i_pc = pc; i_result = res;
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic test_reset();
      rst_n = 0; model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (o_wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", o_wb_valid); end
      checks++; if (o_wb_rd !== 5'd0) begin failures++; $display("FAIL reset_wb_rd got=%0d exp=0", o_wb_rd); end
      checks++; if (o_wb_data !== 256'd0) begin failures++; $display("FAIL reset_wb_data got=%h exp=0", o_wb_data); end
      checks++; if (o_redirect !== 1'b0) begin failures++; $display("FAIL reset_redirect got=%b exp=0", o_redirect); end
      checks++; if (o_redirect_pc !== 11'd0) begin failures++; $display("FAIL reset_redirect_pc got=%h exp=0", o_redirect_pc); end
      checks++; if (o_carry !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", o_carry); end
      checks++; if (o_nzp !== 3'b010) begin failures++; $display("FAIL reset_nzp got=%b exp=010", o_nzp); end
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_add_write();
      i_wb_ready = 0;
      drive(1, 5'b00101, 5'd3, 11'd0, 256'd0);
      tick();
      i_valid = 0;
      checks++; if (o_nzp !== 3'b010) begin failures++; $display("FAIL add_nzp got=%b exp=010", o_nzp); end
      checks++; if (o_wb_valid !== 1'b1) begin failures++; $display("FAIL add_wb_valid got=%b exp=1", o_wb_valid); end
      checks++; if (o_wb_rd !== 5'd3) begin failures++; $display("FAIL add_wb_rd got=%0d exp=3", o_wb_rd); end
      checks++; if (o_wb_data !== 256'd0) begin failures++; $display("FAIL add_wb_data got=%h exp=0", o_wb_data); end
      checks++; if (o_redirect !== 1'b0) begin failures++; $display("FAIL add_redirect got=%b exp=0", o_redirect); end
      i_wb_ready = 1;
      tick();
      checks++; if (o_wb_valid !== 1'b0) begin failures++; $display("FAIL add_drain got=%b exp=0", o_wb_valid); end
   endtask

   task automatic test_branch_squash();
      drive(1, 5'b00110, 5'd1, 11'd0, {1'b1, 255'd77});
      tick();
      checks++; if (o_nzp !== 3'b100) begin failures++; $display("FAIL sub_nzp got=%b exp=100", o_nzp); end
      drive(1, 5'b00100, 5'd0, 11'd0, 256'h123);
      tick();
      checks++; if (o_redirect !== 1'b1) begin failures++; $display("FAIL brnz_redirect got=%b exp=1", o_redirect); end
      checks++; if (o_redirect_pc !== 11'h123) begin failures++; $display("FAIL brnz_pc got=%h exp=123", o_redirect_pc); end
      drive(1, 5'b00101, 5'd5, 11'd0, 256'd1);
      tick();
      i_valid = 0;
      checks++; if (o_redirect !== 1'b0) begin failures++; $display("FAIL pulse_width got=%b exp=0", o_redirect); end
      checks++; if (o_wb_valid !== 1'b0) begin failures++; $display("FAIL squash_write got=%b exp=0", o_wb_valid); end
      checks++; if (o_nzp !== 3'b100) begin failures++; $display("FAIL squash_nzp got=%b exp=100", o_nzp); end
      checks++; if (o_redirect_pc !== 11'h123) begin failures++; $display("FAIL pc_hold got=%h exp=123", o_redirect_pc); end
   endtask

   task automatic test_carry();
      drive(1, 5'b10000, 5'd2, 11'd0, {256{1'b1}});
      tick();
      checks++; if (o_carry !== 1'b1) begin failures++; $display("FAIL chkl_carry got=%b exp=1", o_carry); end
      checks++; if (o_wb_valid !== 1'b0) begin failures++; $display("FAIL chkl_write got=%b exp=0", o_wb_valid); end
      checks++; if (o_nzp !== 3'b100) begin failures++; $display("FAIL chkl_nzp got=%b exp=100", o_nzp); end
      drive(1, 5'b10011, 5'd2, 11'd0, 256'd1);
      tick();
      i_valid = 0;
      checks++; if (o_carry !== 1'b0) begin failures++; $display("FAIL chkh_carry got=%b exp=0", o_carry); end
      checks++; if (o_nzp !== 3'b100) begin failures++; $display("FAIL chkh_nzp got=%b exp=100", o_nzp); end
   endtask

   task automatic test_backpressure();
      logic [255:0] a, b;
      a = {1'b0, 255'h1234_5678_9abc};
      b = 256'h5a5a;
      i_wb_ready = 0;
      drive(1, 5'b00101, 5'd2, 11'd0, a);
      tick();
      drive(1, 5'b00101, 5'd4, 11'd0, b);
      for (int c = 0; c < 3; c++) begin
         checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL stall_ready c=%0d got=%b exp=0", c, o_ready); end
         tick();
         checks++; if (o_wb_rd !== 5'd2 || o_wb_data !== a || o_wb_valid !== 1'b1)
            begin failures++; $display("FAIL stall_hold c=%0d rd=%0d v=%b data=%h", c, o_wb_rd, o_wb_valid, o_wb_data); end
      end
      i_wb_ready = 1;
      #1;
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", o_ready); end
      tick();
      i_valid = 0;
      checks++; if (o_wb_valid !== 1'b1 || o_wb_rd !== 5'd4 || o_wb_data !== b)
         begin failures++; $display("FAIL replace v=%b rd=%0d data=%h exp rd=4 data=%h", o_wb_valid, o_wb_rd, o_wb_data, b); end
      checks++; if (o_nzp !== 3'b001) begin failures++; $display("FAIL bp_nzp got=%b exp=001", o_nzp); end
   endtask

   task automatic test_jsr();
      drive(1, 5'b01000, 5'd9, 11'h7FF, {245'h1abcd, 11'h2AB});
      tick();
      i_valid = 0;
      checks++; if (o_wb_valid !== 1'b1 || o_wb_rd !== 5'd7) begin failures++; $display("FAIL jsr_rd v=%b got=%0d exp=7", o_wb_valid, o_wb_rd); end
      checks++; if (o_wb_data !== 256'h800) begin failures++; $display("FAIL jsr_link got=%h exp=800", o_wb_data); end
      checks++; if (o_redirect !== 1'b1 || o_redirect_pc !== 11'h2AB) begin failures++; $display("FAIL jsr_redirect r=%b pc=%h exp=2ab", o_redirect, o_redirect_pc); end
      checks++; if (o_nzp !== 3'b001) begin failures++; $display("FAIL jsr_nzp got=%b exp=001", o_nzp); end
      tick();
   endtask

   task automatic test_random();
      logic [255:0] r;
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 3))
            0: r = 256'd0;
            1: r = {1'b1, rand256() >> 1};
            2: r = 256'($urandom_range(0, 4095));
            default: r = rand256();
         endcase
         drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 5'($urandom),
               11'($urandom), r);
         i_wb_ready = $urandom_range(0, 4) < 3;
         #1;
         checks++; if (o_ready !== (!m_wbv || i_wb_ready)) begin failures++; $display("FAIL rnd_ready n=%0d got=%b", n, o_ready); end
         tick();
         checks++; if (o_wb_valid !== m_wbv || o_wb_rd !== m_rd || o_wb_data !== m_data)
            begin failures++; $display("FAIL rnd_wb n=%0d v=%b/%b rd=%0d/%0d data=%h/%h", n, o_wb_valid, m_wbv, o_wb_rd, m_rd, o_wb_data, m_data); end
         checks++; if (o_nzp !== m_nzp || o_carry !== m_carry)
            begin failures++; $display("FAIL rnd_flags n=%0d nzp=%b/%b carry=%b/%b", n, o_nzp, m_nzp, o_carry, m_carry); end
         checks++; if (o_redirect !== m_redir || o_redirect_pc !== m_rpc)
            begin failures++; $display("FAIL rnd_redirect n=%0d r=%b/%b pc=%h/%h", n, o_redirect, m_redir, o_redirect_pc, m_rpc); end
      end
      i_valid = 0; i_wb_ready = 1;
      tick();
   endtask

   task automatic test_reset_stall();
      i_wb_ready = 1;
      drive(1, 5'b10000, 5'd0, 11'd0, 256'd1);
      tick();
      i_wb_ready = 0;
      drive(1, 5'b00101, 5'd6, 11'd0, {1'b1, 255'd3});
      tick();
      i_valid = 0;
      checks++; if (o_wb_valid !== 1'b1 || o_carry !== 1'b1) begin failures++; $display("FAIL pre_reset v=%b carry=%b exp 1 1", o_wb_valid, o_carry); end
      #2;
      rst_n = 0; model_reset();
      #1;
      checks++; if (o_wb_valid !== 1'b0) begin failures++; $display("FAIL async_drop got=%b exp=0", o_wb_valid); end
      @(negedge clk);
      rst_n = 1;
      i_wb_ready = 1;
      tick();
      checks++; if (o_carry !== 1'b0) begin failures++; $display("FAIL post_reset_carry got=%b exp=0", o_carry); end
      checks++; if (o_nzp !== 3'b010) begin failures++; $display("FAIL post_reset_nzp got=%b exp=010", o_nzp); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      test_reset();
      test_add_write();
      test_branch_squash();
      test_carry();
      test_backpressure();
      test_jsr();
      test_random();
      test_reset_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
